stage1_cm_filter: RTL and testbench

- Parametrised successor to the two-row stage-1 frequency filter in front of the SketchPolymer stage-2 sketch.
- Holds ROWS count-min rows in external dual-port RAMs, with one RAM per row.
- Accepts insert/search operations through a valid/ready handshake and returns min-frequency results in order.
- Adds over the previous generation: N rows, counter saturation, read-after-write forwarding for back-to-back keys, and a RAM clear sweep.

---
 rtl/stage1_pkg.sv | 29 ++
 rtl/stage1_row_hash.sv | 30 +++
 rtl/stage1_cm_filter.sv | 142 ++++++++++++++
 tb/tb_stage1_cm_filter.sv | 301 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/stage1_pkg.sv
// stage1_pkg: shared constants and helpers for the stage-1 count-min filter
//   OP_INSERT/OP_SEARCH : operation encoding on in_op_i / res_op_o
//   CRC32_POLY          : reflected CRC-32 polynomial used by the row hashes
//   HASH_SEED           : per-row key seeds, one per possible row (up to 8)
//   sat_inc             : increment that sticks at the supplied maximum
package stage1_pkg;

    localparam logic OP_INSERT = 1'b0;
    localparam logic OP_SEARCH = 1'b1;

    localparam logic [31:0] CRC32_POLY = 32'hEDB8_8320;

    localparam logic [63:0] HASH_SEED [8] = '{
        64'h9E37_79B9_7F4A_7C15,
        64'hC2B2_AE3D_27D4_EB4F,
        64'h1656_67B1_9E37_79F9,
        64'h85EB_CA77_C2B2_AE63,
        64'h27D4_EB2F_1656_67C5,
        64'hFF51_AFD7_ED55_8CCD,
        64'hC4CE_B9FE_1A85_EC53,
        64'h2545_F491_4F6C_DD1D
    };

    // Callers zero-extend a CW-bit counter into 64 bits and cast the result back.
    function automatic logic [63:0] sat_inc(input logic [63:0] v, input logic [63:0] max_v);
        return (v == max_v) ? v : v + 64'd1;
    endfunction

endpackage

// File: rtl/stage1_row_hash.sv
// stage1_row_hash: registered CRC-32 row hash of (key ^ HASH_SEED[ROW]), low HW bits
//   clk, rst : clock, synchronous active-high reset (hash returns to 0)
//   key      : KW-bit key, hashed every cycle
//   hash     : HW-bit row address, one cycle after key
module stage1_row_hash
    import stage1_pkg::*;
#(
    parameter int KW  = 64,
    parameter int HW  = 10,
    parameter int ROW = 0
) (
    input  logic          clk,
    input  logic          rst,
    input  logic [KW-1:0] key,
    output logic [HW-1:0] hash
);

    // Standard reflected CRC-32, key bit 0 shifted in first.
    function automatic logic [31:0] crc32(input logic [KW-1:0] d);
        logic [31:0] c;
        c = '1;
        for (int i = 0; i < KW; i++)
            c = (c >> 1) ^ ((c[0] ^ d[i]) ? CRC32_POLY : 32'h0);
        return ~c;
    endfunction

    always_ff @(posedge clk)
        hash <= rst ? '0 : HW'(crc32(key ^ KW'(HASH_SEED[ROW])));

endmodule

// File: rtl/stage1_cm_filter.sv
// stage1_cm_filter: ROWS-row count-min frequency filter with forwarding, saturation and clear sweep
//   in_valid_i/in_ready_o/in_op_i/in_key_i/freq_threshold_i : operation request handshake
//   clear_i/busy_o          : start a zeroing sweep of every row / sweep in progress
//   res_valid_o/res_op_o/res_freq_o/res_pass_o : in-order result, 3 cycles after accept
//   ram_rd_addr_o/ram_rd_data_i : per-row read port, 1-cycle registered latency
//   ram_wr_en_o/ram_wr_addr_o/ram_wr_data_o : per-row write port
//   STAGE1_CONSERVATIVE_UPDATE_EN : when defined, only rows at the min are incremented
module stage1_cm_filter
    import stage1_pkg::*;
#(
    parameter int ROWS = 2,
    parameter int HW   = 10,
    parameter int KW   = 64,
    parameter int CW   = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid_i,
    output logic              in_ready_o,
    input  logic              in_op_i,
    input  logic [KW-1:0]     in_key_i,
    input  logic [CW-1:0]     freq_threshold_i,
    input  logic              clear_i,
    output logic              busy_o,
    output logic              res_valid_o,
    output logic              res_op_o,
    output logic [CW-1:0]     res_freq_o,
    output logic              res_pass_o,
    output logic [ROWS*HW-1:0] ram_rd_addr_o,
    input  logic [ROWS*CW-1:0] ram_rd_data_i,
    output logic [ROWS-1:0]   ram_wr_en_o,
    output logic [ROWS*HW-1:0] ram_wr_addr_o,
    output logic [ROWS*CW-1:0] ram_wr_data_o
);

    localparam logic [CW-1:0] CMAX = '1;
    localparam logic [HW-1:0] AMAX = '1;

    logic [HW-1:0] h   [ROWS];
    logic [HW-1:0] a2  [ROWS];
    logic [HW-1:0] fa  [ROWS];
    logic [CW-1:0] fd  [ROWS];
    logic          fv  [ROWS];
    logic [CW-1:0] cnt [ROWS];
    logic [CW-1:0] inc [ROWS];
    logic [ROWS-1:0] we;
    logic [CW-1:0] th1, th2, mn;
    logic [HW-1:0] ca;
    logic v1, v2, op1, op2, rdy, busy, pend;
    logic acc, start, busy_n, upd;

    assign in_ready_o = rdy;
    assign busy_o     = busy;
    assign acc        = in_valid_i && rdy;
    // A clear only starts on an empty pipe with nothing entering it this cycle.
    assign start      = (clear_i || pend) && !busy && !v1 && !v2 && !acc;
    assign busy_n     = start || (busy && ca != AMAX);

    for (genvar r = 0; r < ROWS; r++) begin : g_row
        stage1_row_hash #(.KW(KW), .HW(HW), .ROW(r)) u_hash (
            .clk  (clk),
            .rst  (rst),
            .key  (in_key_i),
            .hash (h[r])
        );
        assign ram_rd_addr_o[r*HW +: HW] = h[r];
        // The RAM returns pre-write data, so the last write to this address wins.
        assign cnt[r] = (fv[r] && fa[r] == a2[r]) ? fd[r] : ram_rd_data_i[r*CW +: CW];
        assign inc[r] = CW'(sat_inc(64'(cnt[r]), 64'(CMAX)));
    end

    always_comb begin
        mn = cnt[0];
        for (int i = 1; i < ROWS; i++)
            mn = (cnt[i] < mn) ? cnt[i] : mn;
        upd = v2 && op2 == OP_INSERT && mn < th2;
        we = '0;
        ram_wr_en_o = '0;
        ram_wr_addr_o = '0;
        ram_wr_data_o = '0;
        for (int i = 0; i < ROWS; i++) begin
`ifdef STAGE1_CONSERVATIVE_UPDATE_EN
            we[i] = upd && cnt[i] == mn;
`else
            we[i] = upd;
`endif
            ram_wr_en_o[i] = busy || we[i];
            ram_wr_addr_o[i*HW +: HW] = busy ? ca : (we[i] ? a2[i] : '0);
            ram_wr_data_o[i*CW +: CW] = we[i] ? inc[i] : '0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rdy <= 1'b0;
            busy <= 1'b0;
            pend <= 1'b0;
            ca <= '0;
            v1 <= 1'b0;
            v2 <= 1'b0;
            op1 <= 1'b0;
            op2 <= 1'b0;
            th1 <= '0;
            th2 <= '0;
            res_valid_o <= 1'b0;
            res_op_o <= 1'b0;
            res_freq_o <= '0;
            res_pass_o <= 1'b0;
            for (int i = 0; i < ROWS; i++)
                fv[i] <= 1'b0;
        end else begin
            rdy <= !busy_n;
            busy <= busy_n;
            pend <= (pend || clear_i) && !start;
            ca <= start ? '0 : (busy ? ca + 1'b1 : ca);
            v1 <= acc;
            op1 <= in_op_i;
            th1 <= freq_threshold_i;
            v2 <= v1;
            op2 <= op1;
            th2 <= th1;
            res_valid_o <= v2;
            if (v2) begin
                res_op_o <= op2;
                res_freq_o <= mn;
                res_pass_o <= mn >= th2;
            end
            for (int i = 0; i < ROWS; i++) begin
                if (busy) begin
                    fv[i] <= 1'b0;
                end else if (we[i]) begin
                    fv[i] <= 1'b1;
                    fa[i] <= a2[i];
                    fd[i] <= inc[i];
                end
            end
        end
        for (int i = 0; i < ROWS; i++)
            a2[i] <= h[i];
    end

endmodule

// File: tb/tb_stage1_cm_filter.sv
// tb_stage1_cm_filter: directed self-checking bench for stage1_cm_filter with a behavioural RAM model
module tb_stage1_cm_filter;
    import stage1_pkg::*;

    localparam int ROWS = 2;
    localparam int HW = 4;
    localparam int KW = 64;
    localparam int CW = 8;
    localparam int DEPTH = 1 << HW;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic in_valid = 1'b0;
    logic in_op = 1'b0;
    logic clear = 1'b0;
    logic [KW-1:0] key = '0;
    logic [CW-1:0] thr = '0;
    logic in_ready, busy, res_valid, res_op, res_pass;
    logic [CW-1:0] res_freq;
    logic [ROWS*HW-1:0] rd_addr, wr_addr;
    logic [ROWS*CW-1:0] rd_data, wr_data;
    logic [ROWS-1:0] wr_en;

    logic [CW-1:0] ram [ROWS][DEPTH];
    logic pre_en = 1'b0;
    int pre_row = 0;
    int pre_addr = 0;
    logic [CW-1:0] pre_data = '0;
    logic wr_seen = 1'b0;

    logic [CW-1:0] fq[$];
    logic pq[$];
    int n_chk = 0;
    int n_pass = 0;

    always #5 clk = ~clk;

    stage1_cm_filter #(.ROWS(ROWS), .HW(HW), .KW(KW), .CW(CW)) dut (
        .clk              (clk),
        .rst              (rst),
        .in_valid_i       (in_valid),
        .in_ready_o       (in_ready),
        .in_op_i          (in_op),
        .in_key_i         (key),
        .freq_threshold_i (thr),
        .clear_i          (clear),
        .busy_o           (busy),
        .res_valid_o      (res_valid),
        .res_op_o         (res_op),
        .res_freq_o       (res_freq),
        .res_pass_o       (res_pass),
        .ram_rd_addr_o    (rd_addr),
        .ram_rd_data_i    (rd_data),
        .ram_wr_en_o      (wr_en),
        .ram_wr_addr_o    (wr_addr),
        .ram_wr_data_o    (wr_data)
    );

    // Read-before-write RAMs with a 1-cycle registered read.
    always @(posedge clk) begin
        for (int r = 0; r < ROWS; r++) begin
            rd_data[r*CW +: CW] <= ram[r][rd_addr[r*HW +: HW]];
            if (wr_en[r])
                ram[r][wr_addr[r*HW +: HW]] <= wr_data[r*CW +: CW];
        end
        if (pre_en)
            ram[pre_row][pre_addr] <= pre_data;
    end

    always @(negedge clk)
        if (res_valid) begin
            fq.push_back(res_freq);
            pq.push_back(res_pass);
        end

    // Byte-wise reflected CRC-32 of (key ^ seed), low HW bits.
    function automatic logic [HW-1:0] haddr(input logic [63:0] k, input int r);
        logic [63:0] d;
        logic [31:0] c;
        d = k ^ HASH_SEED[r];
        c = 32'hFFFF_FFFF;
        for (int b = 0; b < 8; b++) begin
            c = c ^ {24'h0, d[b*8 +: 8]};
            for (int j = 0; j < 8; j++)
                c = c[0] ? ((c >> 1) ^ 32'hEDB8_8320) : (c >> 1);
        end
        c = ~c;
        return c[HW-1:0];
    endfunction

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        wr_seen = wr_seen | (|wr_en);
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    task automatic poke(input int r, input int a, input logic [CW-1:0] v);
        pre_en = 1'b1;
        pre_row = r;
        pre_addr = a;
        pre_data = v;
        tick();
        pre_en = 1'b0;
    endtask

    task automatic send(input logic op, input logic [KW-1:0] k, input logic [CW-1:0] t);
        in_valid = 1'b1;
        in_op = op;
        key = k;
        thr = t;
        tick();
        in_valid = 1'b0;
    endtask

    task automatic res_chk(input string tag, input int i, input logic [CW-1:0] f, input logic p);
        if (i < fq.size()) begin
            chk({tag, "_freq"}, 64'(fq[i]), 64'(f));
            chk({tag, "_pass"}, 64'(pq[i]), 64'(p));
        end else begin
            chk({tag, "_missing"}, 64'(fq.size()), 64'(i + 1));
        end
    endtask

    // Waits (bounded) for the sweep, then checks its length, ready and RAM contents.
    task automatic sweep(input string tag);
        int n = 0;
        int w = 0;
        int nz = 0;
        logic rdy_hi = 1'b0;
        while (!busy && w < 20) begin
            tick();
            w++;
        end
        while (busy && n < 100) begin
            rdy_hi = rdy_hi | in_ready;
            tick();
            n++;
        end
        chk({tag, "_busy_cycles"}, 64'(n), 64'(DEPTH));
        chk({tag, "_ready_low"}, 64'(rdy_hi), 64'd0);
        chk({tag, "_ready_after"}, 64'(in_ready), 64'd1);
        for (int r = 0; r < ROWS; r++)
            for (int a = 0; a < DEPTH; a++)
                if (ram[r][a] !== '0) nz++;
        chk({tag, "_ram_zero"}, 64'(nz), 64'd0);
    endtask

    task automatic do_clear(input string tag);
        clear = 1'b1;
        tick();
        clear = 1'b0;
        sweep(tag);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        logic [KW-1:0] k1, k2, k3, k4;
        k1 = 64'h1234;
        k2 = 64'hDEAD_BEEF_0000_0042;
        k3 = 64'h0BAD_F00D_1357_2468;
        k4 = 64'h0000_0000_00C0_FFEE;

        // garbage fill while held in reset
        for (int r = 0; r < ROWS; r++)
            for (int a = 0; a < DEPTH; a++)
                poke(r, a, CW'(8'hA5 ^ a));
        chk("rst_ready", 64'(in_ready), 64'd0);
        chk("rst_busy", 64'(busy), 64'd0);
        chk("rst_res_valid", 64'(res_valid), 64'd0);
        chk("rst_res_op", 64'(res_op), 64'd0);
        chk("rst_res_freq", 64'(res_freq), 64'd0);
        chk("rst_res_pass", 64'(res_pass), 64'd0);
        chk("rst_wr_en", 64'(wr_en), 64'd0);
        chk("rst_wr_addr", 64'(wr_addr), 64'd0);
        chk("rst_wr_data", 64'(wr_data), 64'd0);
        chk("rst_rd_addr", 64'(rd_addr), 64'd0);
        rst = 1'b0;
        tick();
        chk("post_rst_ready", 64'(in_ready), 64'd1);

        do_clear("clr0");

        // single insert: exact latency and write addresses
        fq.delete(); pq.delete();
        send(OP_INSERT, k1, 8'd3);
        chk("t1_rd_addr", 64'(rd_addr), 64'({haddr(k1, 1), haddr(k1, 0)}));
        tick();
        chk("t1_valid_t2", 64'(res_valid), 64'd0);
        chk("t1_wr_en", 64'(wr_en), 64'b11);
        chk("t1_wr_addr", 64'(wr_addr), 64'({haddr(k1, 1), haddr(k1, 0)}));
        chk("t1_wr_data", 64'(wr_data), 64'h0101);
        tick();
        chk("t1_valid_t3", 64'(res_valid), 64'd1);
        chk("t1_op", 64'(res_op), 64'(OP_INSERT));
        chk("t1_freq", 64'(res_freq), 64'd0);
        chk("t1_pass", 64'(res_pass), 64'd0);
        chk("t1_row0", 64'(ram[0][haddr(k1, 0)]), 64'd1);
        chk("t1_row1", 64'(ram[1][haddr(k1, 1)]), 64'd1);
        tick();
        chk("t1_pulse", 64'(res_valid), 64'd0);

        // four back-to-back inserts of one key
        do_clear("clr1");
        fq.delete(); pq.delete();
        in_valid = 1'b1; in_op = OP_INSERT; key = k2; thr = 8'd3;
        run(4);
        in_valid = 1'b0;
        run(5);
        chk("t2_count", 64'(fq.size()), 64'd4);
        res_chk("t2_r0", 0, 8'd0, 1'b0);
        res_chk("t2_r1", 1, 8'd1, 1'b0);
        res_chk("t2_r2", 2, 8'd2, 1'b0);
        res_chk("t2_r3", 3, 8'd3, 1'b1);
        chk("t2_row0", 64'(ram[0][haddr(k2, 0)]), 64'd3);
        chk("t2_row1", 64'(ram[1][haddr(k2, 1)]), 64'd3);

        // search returns the count and never writes
        fq.delete(); pq.delete(); wr_seen = 1'b0;
        send(OP_SEARCH, k2, 8'd5);
        run(4);
        res_chk("t2s", 0, 8'd3, 1'b0);
        chk("t2s_no_write", 64'(wr_seen), 64'd0);

        // saturation
        do_clear("clr2");
        poke(0, haddr(k3, 0), 8'hFF);
        poke(1, haddr(k3, 1), 8'hFF);
        fq.delete(); pq.delete(); wr_seen = 1'b0;
        send(OP_INSERT, k3, 8'hFF);
        run(4);
        res_chk("t3a", 0, 8'hFF, 1'b1);
        chk("t3a_no_write", 64'(wr_seen), 64'd0);
        poke(1, haddr(k3, 1), 8'd3);
        fq.delete(); pq.delete();
        send(OP_INSERT, k3, 8'hFF);
        run(4);
        res_chk("t3b", 0, 8'd3, 1'b0);
        chk("t3b_row0_sat", 64'(ram[0][haddr(k3, 0)]), 64'hFF);
        chk("t3b_row1", 64'(ram[1][haddr(k3, 1)]), 64'd4);

        // update policy: rows above the min
        do_clear("clr3");
        poke(0, haddr(k4, 0), 8'd5);
        poke(1, haddr(k4, 1), 8'd2);
        fq.delete(); pq.delete();
        send(OP_INSERT, k4, 8'd10);
        run(4);
        res_chk("t4", 0, 8'd2, 1'b0);
        chk("t4_row1", 64'(ram[1][haddr(k4, 1)]), 64'd3);
`ifdef STAGE1_CONSERVATIVE_UPDATE_EN
        chk("t4_row0", 64'(ram[0][haddr(k4, 0)]), 64'd5);
`else
        chk("t4_row0", 64'(ram[0][haddr(k4, 0)]), 64'd6);
`endif

        // clear arriving with two inserts in flight (second one simultaneous)
        fq.delete(); pq.delete();
        send(OP_INSERT, k4, 8'd10);
        clear = 1'b1;
        send(OP_INSERT, k4, 8'd10);
        clear = 1'b0;
        chk("t5_not_busy_yet", 64'(busy), 64'd0);
        sweep("t5");
        chk("t5_count", 64'(fq.size()), 64'd2);
        res_chk("t5_r0", 0, 8'd3, 1'b0);
        res_chk("t5_r1", 1, 8'd4, 1'b0);

        // reset in the middle of the pipeline
        fq.delete(); pq.delete();
        send(OP_INSERT, k1, 8'd3);
        rst = 1'b1;
        tick();
        chk("t6_res_valid", 64'(res_valid), 64'd0);
        chk("t6_wr_en", 64'(wr_en), 64'd0);
        chk("t6_ready_in_rst", 64'(in_ready), 64'd0);
        rst = 1'b0;
        tick();
        chk("t6_ready_after", 64'(in_ready), 64'd1);
        run(4);
        chk("t6_no_result", 64'(fq.size()), 64'd0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
